byte_to_word_packer: RTL and testbench

BYTE_TO_WORD_PACKER -- requirements
Module: byte_to_word_packer

---
 rtl/byte_to_word_packer_pkg.sv | 25 ++
 rtl/handshake_word_fifo.sv | 79 +++++++
 rtl/byte_to_word_packer.sv | 71 +++++++
 tb/tb_byte_to_word_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_to_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_to_word_packer_pkg
// Description : Shared widths, types and byte-placement helper for the
//               byte-to-word packer.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_to_word_packer_pkg;

    localparam int c_BYTE_W         = 8;
    localparam int c_WORD_W         = 64;
    localparam int c_BYTES_PER_WORD = 8;
    localparam int c_IDX_W          = 3;

    typedef logic [c_BYTE_W-1:0] byte_t;
    typedef logic [c_WORD_W-1:0] word_t;
    typedef logic [c_IDX_W-1:0]  idx_t;

    // Byte k lands at bit offset 8*(7-k), i.e. {~k, 3'b000}, so byte 0 is the MSB.
    function automatic word_t place_byte(input byte_t b, input idx_t k);
        return word_t'(b) << {~k, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : handshake_word_fifo
// Description : Circular FIFO with isReady/canReceive handshakes on both
//               sides, synchronous flush, output forced to zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in,
    input  logic             in_isReady,
    output logic             in_canReceive,
    output logic [WIDTH-1:0] out,
    output logic             out_isReady,
    input  logic             out_canReceive
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Readiness depends only on occupancy and reset, never on the data-side inputs.
    assign in_canReceive = !rst && (r_count < c_CNT_W'(DEPTH));
    assign out_isReady   = (r_count != '0);
    assign out           = out_isReady ? r_mem[r_rd_ptr] : '0;

    assign w_push = in_isReady && in_canReceive;
    assign w_pop  = out_isReady && out_canReceive;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Storage write; slot contents need no reset because out is gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= in;
        end
    end

    // Pointer and occupancy bookkeeping; clear overrides any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/byte_to_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_to_word_packer
// Description : Packs a host byte stream MSB-first into 64-bit words; a word
//               is committed on its 8th byte or on a byte flagged in_last,
//               then queued for the core in a small handshake FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_to_word_packer
    import byte_to_word_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [c_BYTE_W-1:0] in,
    input  logic                in_last,
    input  logic                in_isReady,
    output logic                in_canReceive,
    output logic [c_WORD_W-1:0] out,
    output logic                out_isReady,
    input  logic                out_canReceive
);

    idx_t  r_idx;
    word_t r_acc;

    logic  w_fifo_can;
    logic  w_byte_xfer;
    logic  w_commit;
    word_t w_word;

    assign w_byte_xfer   = in_isReady && w_fifo_can;
    assign w_commit      = w_byte_xfer &&
                           (in_last || (r_idx == idx_t'(c_BYTES_PER_WORD - 1)));
    // Later byte positions are still zero in the accumulator, giving zero fill on a short field.
    assign w_word        = r_acc | place_byte(in, r_idx);
    assign in_canReceive = w_fifo_can;

    // Byte index and partial-word accumulator; cleared on commit, flush or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (clear || w_commit) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (w_byte_xfer) begin
            r_idx <= r_idx + idx_t'(1);
            r_acc <= w_word;
        end
    end

    handshake_word_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .in             (w_word),
        .in_isReady     (w_commit),
        .in_canReceive  (w_fifo_can),
        .out            (out),
        .out_isReady    (out_isReady),
        .out_canReceive (out_canReceive)
    );

endmodule
`default_nettype wire

// File: tb/tb_byte_to_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_to_word_packer
// Description : Self-checking bench for byte_to_word_packer with a queue
//               based reference model and directed plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_byte_to_word_packer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [7:0]  in;
    logic        in_last;
    logic        in_isReady;
    logic        in_canReceive;
    logic [63:0] out;
    logic        out_isReady;
    logic        out_canReceive;

    always #5 clk = ~clk;

    byte_to_word_packer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .in             (in),
        .in_last        (in_last),
        .in_isReady     (in_isReady),
        .in_canReceive  (in_canReceive),
        .out            (out),
        .out_isReady    (out_isReady),
        .out_canReceive (out_canReceive)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_bytes [$];   // bytes of the word being assembled
    logic [63:0] m_q     [$];   // words the block should currently hold
    logic [63:0] seen    [$];   // words the DUT actually handed over
    bit          m_acc;         // last cycle transferred a byte

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] build_word();
        logic [63:0] w = 64'h0;
        for (int i = 0; i < 8; i++) begin
            w = w * 64'd256 + ((i < m_bytes.size()) ? 64'(m_bytes[i]) : 64'h0);
        end
        return w;
    endfunction

    function automatic logic [63:0] seq_word(input int s);
        logic [63:0] w = 64'h0;
        for (int i = 0; i < 8; i++) begin
            w = w * 64'd256 + 64'((s + i) % 256);
        end
        return w;
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cyc();
        bit can;
        bit bx;
        bit wx;
        @(negedge clk);
        can = !rst && (m_q.size() < DEPTH);
        chk("in_canReceive", 64'(in_canReceive), 64'(can));
        chk("out_isReady", 64'(out_isReady), 64'(m_q.size() > 0));
        chk("out", out, (m_q.size() > 0) ? m_q[0] : 64'h0);
        bx = in_isReady && can;
        wx = out_canReceive && (m_q.size() > 0) && !rst;
        if (wx && !clear) seen.push_back(out);
        m_acc = bx && !clear;
        @(posedge clk);
        if (rst || clear) begin
            m_q.delete();
            m_bytes.delete();
        end else begin
            if (wx) void'(m_q.pop_front());
            if (bx) begin
                m_bytes.push_back(in);
                if (in_last || m_bytes.size() == 8) begin
                    m_q.push_back(build_word());
                    m_bytes.delete();
                end
            end
        end
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int n = 0;
        in = b; in_last = last; in_isReady = 1'b1;
        do begin
            cyc();
            n++;
        end while (!m_acc && n < 200);
        if (!m_acc) chk("send_timeout", 64'(m_acc), 64'd1);
        in_isReady = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain(input int n);
        out_canReceive = 1'b1;
        repeat (n) cyc();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int n;
        int drops;

        rst = 1'b1; clear = 1'b0; in = 8'h00; in_last = 1'b0;
        in_isReady = 1'b0; out_canReceive = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Back-to-back stream 0x00..0x0F
        seen.delete();
        out_canReceive = 1'b1;
        for (int k = 0; k < 16; k++) begin
            send(8'(k), 1'b0);
            if (k == 6) chk("stream_early", 64'(out_isReady), 64'd0);
            if (k == 7) chk("stream_latency", 64'(out_isReady), 64'd1);
        end
        drain(3);
        chk("stream_count", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) begin
            chk("stream_w0", seen[0], 64'h0001020304050607);
            chk("stream_w1", seen[1], 64'h08090A0B0C0D0E0F);
        end

        // Short fields
        seen.delete();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        send(8'h11, 1'b1);
        drain(3);
        chk("short_count", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) begin
            chk("short_w0", seen[0], 64'hAABBCC0000000000);
            chk("short_w1", seen[1], 64'h1100000000000000);
        end

        // in_last on the 8th byte gives exactly one word
        seen.delete();
        for (int k = 0; k < 8; k++) send(8'(8'h40 + k), k == 7);
        drain(3);
        chk("last7_count", 64'(seen.size()), 64'd1);
        if (seen.size() == 1) chk("last7_w", seen[0], seq_word(8'h40));

        // Backpressure: 24 bytes into a stalled core
        seen.delete();
        out_canReceive = 1'b0;
        i = 0; n = 0;
        while (i < 16 && n < 200) begin
            in = 8'(8'h30 + i); in_isReady = 1'b1; cyc(); n++;
            if (m_acc) i++;
        end
        chk("bp_full", 64'(in_canReceive), 64'd0);
        repeat (3) begin
            cyc();
            chk("bp_hold", 64'(in_canReceive), 64'd0);
        end
        out_canReceive = 1'b1;
        while (i < 24 && n < 200) begin
            in = 8'(8'h30 + i); in_isReady = 1'b1; cyc(); n++;
            if (m_acc) i++;
        end
        in_isReady = 1'b0;
        drain(6);
        chk("bp_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            for (int k = 0; k < 3; k++) chk("bp_word", seen[k], seq_word(8'h30 + 8 * k));
        end

        // Clear flushes queued and partial words
        seen.delete();
        out_canReceive = 1'b0;
        for (int k = 0; k < 8; k++) send(8'(8'h50 + k), 1'b0);
        for (int k = 0; k < 5; k++) send(8'(8'h60 + k), 1'b0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_rdy", 64'(out_isReady), 64'd0);
        out_canReceive = 1'b1;
        for (int k = 0; k < 8; k++) send(8'(8'h80 + k), 1'b0);
        drain(3);
        chk("clear_count", 64'(seen.size()), 64'd1);
        if (seen.size() == 1) chk("clear_w", seen[0], 64'h8081828384858687);

        // Asynchronous reset mid-word with a word queued
        seen.delete();
        out_canReceive = 1'b0;
        for (int k = 0; k < 8; k++) send(8'(8'h20 + k), 1'b0);
        for (int k = 0; k < 3; k++) send(8'(8'hA0 + k), 1'b0);
        #2;
        chk("pre_rst_rdy", 64'(out_isReady), 64'd1);
        rst = 1'b1;
        m_q.delete();
        m_bytes.delete();
        #1;
        chk("rst_out_isReady", 64'(out_isReady), 64'd0);
        chk("rst_out", out, 64'h0);
        chk("rst_in_canReceive", 64'(in_canReceive), 64'd0);
        cyc();
        cyc();
        rst = 1'b0;
        out_canReceive = 1'b1;
        for (int k = 0; k < 8; k++) send(8'(8'hF0 + k), 1'b0);
        drain(3);
        chk("rst_count", 64'(seen.size()), 64'd1);
        if (seen.size() == 1) chk("rst_w", seen[0], 64'hF0F1F2F3F4F5F6F7);

        // Throughput: 800 continuous bytes
        seen.delete();
        out_canReceive = 1'b1;
        drops = 0;
        in_isReady = 1'b1; in_last = 1'b0;
        for (int k = 0; k < 800; k++) begin
            in = 8'($urandom);
            if (!in_canReceive) drops++;
            cyc();
        end
        in_isReady = 1'b0;
        drain(3);
        chk("tp_drops", 64'(drops), 64'd0);
        chk("tp_words", 64'(seen.size()), 64'd100);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            in             = 8'($urandom);
            in_isReady     = ($urandom_range(0, 3) != 0);
            in_last        = ($urandom_range(0, 7) == 0);
            out_canReceive = ($urandom_range(0, 2) != 0);
            clear          = ($urandom_range(0, 63) == 0);
            cyc();
        end
        in_isReady = 1'b0; in_last = 1'b0; clear = 1'b0;
        drain(6);
        chk("rand_empty", 64'(out_isReady), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
